jt6295_sched: RTL and testbench

- 4-voice playback scheduler for the ADPCM decoder.
- Holds per-voice start/stop byte addresses and attenuation, and prefetches sample bytes from ROM over a req/ok handshake.
- On every cen it issues one nibble plus enable for the voice owning the current slot. This matches the decoder's 4-stage time-multiplexed pipeline, so each slot maps to one voice.
- Sits between the command decoder (register writes) and the ADPCM datapath.

---
 rtl/jt6295_pkg.sv | 20 ++
 rtl/jt6295_fetch_arb.sv | 75 +++++++
 rtl/jt6295_sched.sv | 158 +++++++++++++++
 tb/tb_jt6295_sched.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt6295_pkg.sv
// Shared constants for the jt6295 playback scheduler.
package jt6295_pkg;

  // Voice count and the width of a slot / voice index.
  localparam int CH     = 4;
  localparam int SW     = 2;

  // Default ROM byte-address width.
  localparam int AW_DEF = 18;

  // Value of a voice's nibble selector that picks the high nibble; the high
  // nibble of every byte is played first.
  localparam logic NIB_FIRST = 1'b0;

  // Nibble of a sample byte selected by the per-voice nibble selector.
  function automatic logic [3:0] pick_nib(input logic [7:0] b, input logic nib);
    return (nib == NIB_FIRST) ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/jt6295_fetch_arb.sv
// jt6295_fetch_arb: round-robin ROM fetch arbiter and request register.
//
// ROM handshake: rom_cs is raised with rom_addr and both are held stable
// until a clk on which rom_ok is sampled high; on that clk rom_data is
// taken and rom_cs drops. A new request is only granted while rom_cs is low,
// so at least one idle clk always separates two requests.
module jt6295_fetch_arb
  import jt6295_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    i_req,
  input  logic [CH*AW-1:0] i_ptr,
  input  logic             i_rom_ok,
  input  logic [7:0]       i_rom_data,
  output logic             o_rom_cs,
  output logic [AW-1:0]    o_rom_addr,
  output logic             o_gnt,
  output logic [SW-1:0]    o_gnt_idx,
  output logic             o_done,
  output logic [SW-1:0]    o_done_idx,
  output logic [7:0]       o_data
);

  logic            r_cs;
  logic [AW-1:0]   r_addr;
  logic [SW-1:0]   r_idx;
  logic [SW-1:0]   r_rr;

  logic            w_found;
  logic [SW-1:0]   w_pick;
  logic [SW-1:0]   w_cand;

  // Pick the first requesting voice at or after the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < CH; k++) begin
      w_cand = r_rr + SW'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  // Request register: grant when idle, hold address until rom_ok.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cs   <= 1'b0;
      r_addr <= '0;
      r_idx  <= '0;
      r_rr   <= '0;
    end else if (r_cs) begin
      if (i_rom_ok) r_cs <= 1'b0;
    end else if (w_found) begin
      r_cs   <= 1'b1;
      r_addr <= i_ptr[w_pick*AW +: AW];
      r_idx  <= w_pick;
      r_rr   <= w_pick + 1'b1;
    end
  end

  assign o_rom_cs   = r_cs;
  assign o_rom_addr = r_addr;
  assign o_gnt      = !r_cs && w_found;
  assign o_gnt_idx  = w_pick;
  assign o_done     = r_cs && i_rom_ok;
  assign o_done_idx = r_idx;
  assign o_data     = i_rom_data;

endmodule

// File: rtl/jt6295_sched.sv
// jt6295_sched: 4-voice ADPCM playback scheduler with ROM byte prefetch.
// Each cen advances the decoder slot and registers one nibble for the voice
// that owns the new slot.
module jt6295_sched
  import jt6295_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic [3:0]    start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] stop_addr,
  input  logic [3:0]    start_att,
  input  logic [3:0]    stop,
  output logic [3:0]    busy,
  output logic [3:0]    underrun,
  input  logic          clr_flags,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic          rom_ok,
  input  logic [7:0]    rom_data,
  output logic [1:0]    slot,
  output logic          adpcm_en,
  output logic [3:0]    adpcm_data,
  output logic [3:0]    adpcm_att
);

  logic [CH-1:0]    r_active;
  logic [CH-1:0]    r_bvalid;
  logic [CH-1:0]    r_nib;
  logic [CH-1:0]    r_under;
  logic [AW-1:0]    r_ptr  [CH];
  logic [AW-1:0]    r_stop [CH];
  logic [3:0]       r_att  [CH];
  logic [7:0]       r_buf  [CH];
  logic             r_live;
  logic [SW-1:0]    r_slot;
  logic             r_en;
  logic [3:0]       r_data;
  logic [3:0]       r_att_o;

  logic [CH-1:0]    w_req;
  logic [CH*AW-1:0] w_ptr_flat;
  logic [SW-1:0]    w_nslot;
  logic             w_gnt;
  logic [SW-1:0]    w_gnt_idx;
  logic             w_done;
  logic [SW-1:0]    w_done_idx;
  logic [7:0]       w_data;

  assign w_req   = r_active & ~r_bvalid;
  assign w_nslot = r_slot + 1'b1;

  // Flatten the per-voice pointers for the arbiter.
  always_comb begin
    w_ptr_flat = '0;
    for (int i = 0; i < CH; i++) w_ptr_flat[i*AW +: AW] = r_ptr[i];
  end

  jt6295_fetch_arb #(.AW(AW)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_req),
    .i_ptr      (w_ptr_flat),
    .i_rom_ok   (rom_ok),
    .i_rom_data (rom_data),
    .o_rom_cs   (rom_cs),
    .o_rom_addr (rom_addr),
    .o_gnt      (w_gnt),
    .o_gnt_idx  (w_gnt_idx),
    .o_done     (w_done),
    .o_done_idx (w_done_idx),
    .o_data     (w_data)
  );

  // Per-voice state: start/stop, nibble consumption, buffer fill, flags.
  // Later assignments in this block take priority (stop over cen end-of-sample,
  // underrun set over clr_flags).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= '0;
      r_bvalid <= '0;
      r_nib    <= '0;
      r_under  <= '0;
      r_live   <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        r_ptr[i]  <= '0;
        r_stop[i] <= '0;
        r_att[i]  <= '0;
        r_buf[i]  <= '0;
      end
    end else begin
      if (clr_flags) r_under <= '0;
      // A fresh grant makes its returning byte usable unless the voice is
      // stopped before the byte arrives.
      if (w_gnt) r_live <= 1'b1;
      for (int i = 0; i < CH; i++) begin
        // Returned byte is kept only for the same, still-playing voice.
        if (w_done && w_done_idx == SW'(i) && r_live && r_active[i] &&
            r_ptr[i] == rom_addr) begin
          r_buf[i]    <= w_data;
          r_bvalid[i] <= 1'b1;
        end
        // Nibble consumption for the voice owning the next slot.
        if (cen && w_nslot == SW'(i) && r_active[i]) begin
          if (r_bvalid[i]) begin
            r_nib[i] <= ~r_nib[i];
            if (r_nib[i] != NIB_FIRST) begin
              r_bvalid[i] <= 1'b0;
              r_ptr[i]    <= r_ptr[i] + 1'b1;
              if (r_ptr[i] == r_stop[i]) r_active[i] <= 1'b0;
            end
          end else begin
            r_under[i] <= 1'b1;
          end
        end
        if (stop[i]) begin
          r_active[i] <= 1'b0;
          if ((rom_cs && w_done_idx == SW'(i)) || (w_gnt && w_gnt_idx == SW'(i)))
            r_live <= 1'b0;
        end else if (start[i] && !r_active[i]) begin
          r_active[i] <= 1'b1;
          r_bvalid[i] <= 1'b0;
          r_nib[i]    <= NIB_FIRST;
          r_ptr[i]    <= start_addr;
          r_stop[i]   <= stop_addr;
          r_att[i]    <= start_att;
        end
      end
    end
  end

  // Slot advance and registered decoder inputs for the new slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot  <= '0;
      r_en    <= 1'b0;
      r_data  <= '0;
      r_att_o <= '0;
    end else if (cen) begin
      r_slot  <= w_nslot;
      r_en    <= r_active[w_nslot];
      r_data  <= (r_active[w_nslot] && r_bvalid[w_nslot]) ?
                 pick_nib(r_buf[w_nslot], r_nib[w_nslot]) : 4'h0;
      r_att_o <= r_active[w_nslot] ? r_att[w_nslot] : 4'h0;
    end
  end

  assign busy       = r_active;
  assign underrun   = r_under;
  assign slot       = r_slot;
  assign adpcm_en   = r_en;
  assign adpcm_data = r_data;
  assign adpcm_att  = r_att_o;

endmodule

// File: tb/tb_jt6295_sched.sv
// Bench for jt6295_sched: directed scenarios plus randomized traffic,
// checked against a voice-level playback model and an output queue.
module tb_jt6295_sched;
  import jt6295_pkg::*;

  localparam int AW = 18;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic [3:0]    start = '0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] stop_addr = '0;
  logic [3:0]    start_att = '0;
  logic [3:0]    stop = '0;
  logic          clr_flags = 1'b0;
  logic          rom_ok = 1'b0;
  logic [7:0]    rom_data = '0;
  logic [3:0]    busy, underrun;
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [1:0]    slot;
  logic          adpcm_en;
  logic [3:0]    adpcm_data, adpcm_att;

  always #5 clk = ~clk;

  jt6295_sched #(.AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .start      (start),
    .start_addr (start_addr),
    .stop_addr  (stop_addr),
    .start_att  (start_att),
    .stop       (stop),
    .busy       (busy),
    .underrun   (underrun),
    .clr_flags  (clr_flags),
    .rom_addr   (rom_addr),
    .rom_cs     (rom_cs),
    .rom_ok     (rom_ok),
    .rom_data   (rom_data),
    .slot       (slot),
    .adpcm_en   (adpcm_en),
    .adpcm_data (adpcm_data),
    .adpcm_att  (adpcm_att)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- ROM contents and responder ----------------
  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
    if (a == 18'h00100) return 8'h12;
    if (a == 18'h00101) return 8'h34;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  int lat  = 0;
  int rcnt = 0;

  // rom_ok rises once rom_cs has been seen high for more than lat clocks.
  always @(negedge clk) begin
    if (rst || !rom_cs) begin
      rcnt   = 0;
      rom_ok = 1'b0;
    end else begin
      rcnt++;
      rom_data = rom_byte(rom_addr);
      rom_ok   = (rcnt > lat);
    end
  end

  // ---------------- cen generator ----------------
  int cen_per = 8;
  int ccnt    = 0;
  bit cen_on  = 1'b0;

  always @(negedge clk) begin
    if (!cen_on) begin
      cen  = 1'b0;
      ccnt = 0;
    end else begin
      ccnt++;
      if (ccnt >= cen_per) begin
        cen  = 1'b1;
        ccnt = 0;
      end else begin
        cen = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Each voice is a pointer into ROM plus "have byte" and "low half next";
  // played nibbles are looked up directly in rom_byte().
  bit            m_act  [4];
  bit            m_have [4];
  bit            m_low  [4];
  logic [AW-1:0] m_ptr  [4];
  logic [AW-1:0] m_stop [4];
  logic [3:0]    m_att  [4];
  logic [3:0]    m_under;
  bit            m_cs;
  int            m_fv;
  logic [AW-1:0] m_faddr;
  bit            m_live;
  int            m_rr;
  int            m_slot;
  bit            m_cen_seen;
  logic [10:0]   exp_q[$];

  always @(posedge clk) begin
    bit          need [4];
    bit          act0 [4];
    bit          set_u [4];
    bit          cs0;
    bit          found;
    int          v;
    logic [7:0]  b;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_act[i] = 0; m_have[i] = 0; m_low[i] = 0;
        m_ptr[i] = '0; m_stop[i] = '0; m_att[i] = '0;
      end
      m_under = '0; m_cs = 0; m_fv = 0; m_faddr = '0; m_live = 0;
      m_rr = 0; m_slot = 0; m_cen_seen = 0;
      exp_q.delete();
    end else begin
      cs0 = m_cs;
      for (int i = 0; i < 4; i++) begin
        need[i]  = m_act[i] && !m_have[i];
        act0[i]  = m_act[i];
        set_u[i] = 0;
      end
      m_cen_seen = cen;
      if (cen) begin
        m_slot = (m_slot + 1) % 4;
        v = m_slot;
        if (!act0[v]) begin
          exp_q.push_back({2'(v), 1'b0, 4'h0, 4'h0});
        end else if (!m_have[v]) begin
          exp_q.push_back({2'(v), 1'b1, 4'h0, m_att[v]});
          set_u[v] = 1;
        end else begin
          b = rom_byte(m_ptr[v]);
          exp_q.push_back({2'(v), 1'b1, (m_low[v] ? b[3:0] : b[7:4]), m_att[v]});
          if (m_low[v]) begin
            m_have[v] = 0;
            if (m_ptr[v] == m_stop[v]) m_act[v] = 0;
            m_ptr[v] = m_ptr[v] + 1'b1;
          end
          m_low[v] = !m_low[v];
        end
      end
      if (cs0) begin
        if (rom_ok) begin
          if (m_live && act0[m_fv]) m_have[m_fv] = 1;
          m_cs = 0;
        end
      end else begin
        found = 0;
        for (int k = 0; k < 4; k++) begin
          v = (m_rr + k) % 4;
          if (!found && need[v]) begin
            found = 1;
            m_fv  = v;
          end
        end
        if (found) begin
          m_cs    = 1;
          m_faddr = m_ptr[m_fv];
          m_live  = 1;
          m_rr    = (m_fv + 1) % 4;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (stop[i]) begin
          m_act[i] = 0;
          if (m_cs && m_fv == i) m_live = 0;
        end else if (start[i] && !act0[i]) begin
          m_act[i]  = 1; m_have[i] = 0; m_low[i] = 0;
          m_ptr[i]  = start_addr; m_stop[i] = stop_addr; m_att[i] = start_att;
        end
      end
      m_under = (clr_flags ? 4'h0 : m_under) |
                {set_u[3], set_u[2], set_u[1], set_u[0]};
    end
  end

  // ---------------- scoreboard monitor ----------------
  bit         log_on = 1'b0;
  logic [3:0] nib_log[$];

  always @(negedge clk) begin
    logic [10:0] e;
    if (!rst) begin
      if (m_cen_seen) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL adpcm_out got=output exp=none t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("adpcm_out", {21'h0, slot, adpcm_en, adpcm_data, adpcm_att}, {21'h0, e});
        end
        if (log_on && slot == 2'd1 && adpcm_en) nib_log.push_back(adpcm_data);
      end
      chk("busy", busy, {m_act[3], m_act[2], m_act[1], m_act[0]});
      chk("underrun", underrun, m_under);
      chk("rom_cs", rom_cs, m_cs);
      if (m_cs) chk("rom_addr", rom_addr, m_faddr);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; inputs hold for exactly one clk.
  task automatic pulse(input logic [3:0] st, input logic [3:0] sp, input logic cl,
                       input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                       input logic [3:0] at);
    start = st; stop = sp; clr_flags = cl;
    start_addr = sa; stop_addr = ea; start_att = at;
    @(negedge clk);
    start = '0; stop = '0; clr_flags = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_busy_clear(input logic [3:0] mask, input int budget, input string name);
    int k = 0;
    while ((busy & mask) != 4'h0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, busy & mask, 4'h0);
  endtask

  task automatic wait_cen_slot(input logic [1:0] t, input int budget, input string name);
    int k = 0;
    while (!(m_cen_seen && slot == t) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, slot, t);
  endtask

  task automatic wait_cs(input logic lvl, input int budget, input string name);
    int k = 0;
    while (rom_cs != lvl && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, rom_cs, lvl);
  endtask

  task automatic wait_under(input int v, input int budget, input string name);
    int k = 0;
    while (!underrun[v] && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, underrun[v], 1);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [3:0]    want [4];
    logic [AW-1:0] sa, ea;
    int            act;
    want = '{4'h1, 4'h2, 4'h3, 4'h4};

    // Reset, then idle cen pulses.
    tick(4);
    rst = 1'b0;
    tick(2);
    chk("rst_out", {12'h0, slot, adpcm_en, adpcm_data, adpcm_att, rom_cs, busy, underrun}, 32'h0);
    chk("rst_addr", rom_addr, 0);
    cen_per = 4;
    cen_on  = 1'b1;
    tick(40);

    // Voice 1 plays 0x100..0x101 with a short ROM latency.
    lat = 0;
    cen_per = 8;
    wait_cen_slot(2'd1, 200, "sync_v1");
    log_on = 1'b1;
    pulse(4'b0010, 4'b0000, 1'b0, 18'h00100, 18'h00101, 4'h3);
    wait_busy_clear(4'b0010, 2000, "v1_done");
    tick(40);
    log_on = 1'b0;
    chk("v1_nib_count", nib_log.size(), 4);
    for (int i = 0; i < 4 && i < nib_log.size(); i++) chk("v1_nib", nib_log[i], want[i]);

    // All voices at once, slower ROM, long cen period.
    lat = 2;
    cen_per = 32;
    wait_cen_slot(2'd0, 400, "sync_all");
    pulse(4'hF, 4'h0, 1'b0, 18'h02000, 18'h02001, 4'h5);
    wait_busy_clear(4'hF, 3000, "all_done");
    chk("all_no_underrun", underrun, 4'h0);

    // ROM slower than a voice period: underrun, then resume, then clear.
    lat = 300;
    cen_per = 8;
    pulse(4'b0001, 4'h0, 1'b0, 18'h03000, 18'h03000, 4'h7);
    wait_under(0, 2000, "v0_underrun");
    lat = 0;
    wait_busy_clear(4'b0001, 2000, "v0_resume_done");
    chk("v0_under_sticky", underrun[0], 1);
    pulse(4'h0, 4'h0, 1'b1, '0, '0, 4'h0);
    chk("v0_under_clr", underrun, 4'h0);

    // Stop voice 2 while its fetch is outstanding.
    lat = 20;
    pulse(4'b0100, 4'h0, 1'b0, 18'h04000, 18'h04003, 4'h2);
    wait_cs(1'b1, 100, "v2_fetch");
    pulse(4'h0, 4'b0100, 1'b0, '0, '0, 4'h0);
    chk("v2_stopped", busy[2], 0);
    wait_cs(1'b0, 200, "v2_fetch_end");
    tick(80);

    // Restart on a busy voice is ignored; same-clk start+stop stays idle.
    lat = 0;
    pulse(4'b0001, 4'h0, 1'b0, 18'h05000, 18'h05005, 4'h9);
    tick(20);
    pulse(4'b0001, 4'h0, 1'b0, 18'h06000, 18'h06001, 4'h1);
    pulse(4'b1000, 4'b1000, 1'b0, 18'h07000, 18'h07001, 4'h4);
    chk("v3_start_stop", busy[3], 0);
    wait_busy_clear(4'hF, 5000, "v0_orig_done");

    // Pointer wrap past the top of the address space.
    cen_per = 4;
    pulse(4'b0010, 4'h0, 1'b0, 18'h3FFFE, 18'h00001, 4'h6);
    wait_busy_clear(4'hF, 3000, "wrap_done");

    // Randomized traffic.
    for (int it = 0; it < 200; it++) begin
      lat     = ($urandom_range(0, 9) == 0) ? 40 : $urandom_range(0, 5);
      cen_per = $urandom_range(2, 12);
      sa      = AW'($urandom_range(0, (1 << AW) - 1));
      ea      = sa + AW'($urandom_range(0, 4));
      act     = $urandom_range(0, 9);
      if (act <= 4)
        pulse(4'($urandom_range(1, 15)), 4'h0, 1'b0, sa, ea, 4'($urandom_range(0, 15)));
      else if (act <= 6)
        pulse(4'h0, 4'($urandom_range(1, 15)), 1'b0, sa, ea, 4'h0);
      else if (act == 7)
        pulse(4'h0, 4'h0, 1'b1, sa, ea, 4'h0);
      else if (act == 8)
        pulse(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 1'b0, sa, ea, 4'h8);
      tick($urandom_range(1, 30));
    end

    // Drain.
    lat = 0;
    pulse(4'h0, 4'hF, 1'b0, '0, '0, 4'h0);
    wait_cs(1'b0, 500, "final_cs_idle");
    tick(20);
    cen_on = 1'b0;
    tick(4);
    chk("exp_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
